// File: rtl/uart_dumper.sv
`default_nettype none
// ============================================================================
// Module   : uart_dumper
// Brief    : Halts the CPU, streams program memory out through the UART TX
//            FIFO MSB byte first, then appends an all-ones terminator word.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef COMMAND_WIDTH
`define COMMAND_WIDTH 32
`endif
`ifndef PROGRAM_MEM_SIZE
`define PROGRAM_MEM_SIZE 256
`endif

module uart_dumper #(
    parameter int TX_DATA_WIDTH = 8,
    parameter int DUMP_WORDS    = `PROGRAM_MEM_SIZE
) (
    input  logic                                        in_clk,
    input  logic                                        in_rst,
    input  logic                                        in_clke,
    input  logic                                        in_dump,
    input  logic                                        in_uart_tx_full,
    output logic                                        out_uart_tx_write,
    output logic [TX_DATA_WIDTH-1:0]                    out_uart_tx_data,
    output logic                                        out_mem_read,
    output logic [(($clog2(`PROGRAM_MEM_SIZE) > 0) ? $clog2(`PROGRAM_MEM_SIZE) : 1)-1:0] out_mem_addr,
    input  logic [`COMMAND_WIDTH-1:0]                   in_mem_data,
    output logic                                        out_cpu_en_reg,
    output logic                                        out_busy,
    output logic                                        out_done
);

    localparam int c_CMD_W = `COMMAND_WIDTH;
    localparam int c_AW    = ($clog2(`PROGRAM_MEM_SIZE) > 0) ? $clog2(`PROGRAM_MEM_SIZE) : 1;
    localparam int c_M     = c_CMD_W / TX_DATA_WIDTH;
    localparam int c_CNT_W = (c_M > 1) ? $clog2(c_M) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(c_M - 1);
    localparam logic [c_AW-1:0]    c_ADDR_LAST = c_AW'(DUMP_WORDS - 1);

    localparam logic [2:0] c_S_IDLE     = 3'd0;
    localparam logic [2:0] c_S_MEM_REQ  = 3'd1;
    localparam logic [2:0] c_S_MEM_WAIT = 3'd2;
    localparam logic [2:0] c_S_LOAD     = 3'd3;
    localparam logic [2:0] c_S_SEND     = 3'd4;
    localparam logic [2:0] c_S_STROBE   = 3'd5;
    localparam logic [2:0] c_S_NEXT     = 3'd6;
    localparam logic [2:0] c_S_DONE     = 3'd7;

    logic [2:0]               r_state,    w_state;
    logic [c_CNT_W-1:0]       r_cnt,      w_cnt;
    logic [c_CMD_W-1:0]       r_shift,    w_shift;
    logic                     r_term,     w_term;
    logic                     r_tx_write, w_tx_write;
    logic [TX_DATA_WIDTH-1:0] r_tx_data,  w_tx_data;
    logic                     r_mem_read, w_mem_read;
    logic [c_AW-1:0]          r_mem_addr, w_mem_addr;
    logic                     r_cpu_en,   w_cpu_en;
    logic                     r_busy,     w_busy;
    logic                     r_done,     w_done;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_state    <= c_S_IDLE;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_term     <= 1'b0;
            r_tx_write <= 1'b0;
            r_tx_data  <= '0;
            r_mem_read <= 1'b0;
            r_mem_addr <= '0;
            r_cpu_en   <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (in_clke) begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_shift    <= w_shift;
            r_term     <= w_term;
            r_tx_write <= w_tx_write;
            r_tx_data  <= w_tx_data;
            r_mem_read <= w_mem_read;
            r_mem_addr <= w_mem_addr;
            r_cpu_en   <= w_cpu_en;
            r_busy     <= w_busy;
            r_done     <= w_done;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_shift    = r_shift;
        w_term     = r_term;
        w_tx_write = r_tx_write;
        w_tx_data  = r_tx_data;
        w_mem_read = r_mem_read;
        w_mem_addr = r_mem_addr;
        w_cpu_en   = r_cpu_en;
        w_busy     = r_busy;
        w_done     = r_done;

        case (r_state)
            c_S_IDLE: begin
                w_cpu_en = 1'b1;
                w_busy   = 1'b0;
                w_done   = 1'b0;
                if (in_dump) begin
                    w_cpu_en   = 1'b0;
                    w_busy     = 1'b1;
                    w_mem_addr = '0;
                    w_term     = 1'b0;
                    w_state    = c_S_MEM_REQ;
                end
            end
            c_S_MEM_REQ: begin
                w_mem_read = 1'b1;
                w_state    = c_S_MEM_WAIT;
            end
            c_S_MEM_WAIT: begin
                w_mem_read = 1'b0;
                w_state    = c_S_LOAD;
            end
            c_S_LOAD: begin
                w_shift = in_mem_data;
                w_cnt   = '0;
                w_state = c_S_SEND;
            end
            c_S_SEND: begin
                // A byte is only issued while the FIFO reports room.
                if (!in_uart_tx_full) begin
                    w_tx_data  = r_shift[c_CMD_W-1 -: TX_DATA_WIDTH];
                    w_tx_write = 1'b1;
                    w_shift    = r_shift << TX_DATA_WIDTH;
                    w_state    = c_S_STROBE;
                end else begin
                    w_tx_write = 1'b0;
                end
            end
            c_S_STROBE: begin
                w_tx_write = 1'b0;
                if (r_cnt < c_CNT_LAST) begin
                    w_cnt   = r_cnt + c_CNT_W'(1);
                    w_state = c_S_SEND;
                end else begin
                    w_cnt   = '0;
                    w_state = c_S_NEXT;
                end
            end
            c_S_NEXT: begin
                // The terminator reuses the SEND path with an all-ones word.
                if (r_term) begin
                    w_state = c_S_DONE;
                end else if (r_mem_addr == c_ADDR_LAST) begin
                    w_shift = '1;
                    w_term  = 1'b1;
                    w_state = c_S_SEND;
                end else begin
                    w_mem_addr = r_mem_addr + c_AW'(1);
                    w_state    = c_S_MEM_REQ;
                end
            end
            c_S_DONE: begin
                w_cpu_en = 1'b1;
                w_done   = 1'b1;
                w_state  = c_S_IDLE;
            end
            default: begin
                w_state = c_S_IDLE;
            end
        endcase
    end

    assign out_uart_tx_write = r_tx_write;
    assign out_uart_tx_data  = r_tx_data;
    assign out_mem_read      = r_mem_read;
    assign out_mem_addr      = r_mem_addr;
    assign out_cpu_en_reg    = r_cpu_en;
    assign out_busy          = r_busy;
    assign out_done          = r_done;

endmodule

`default_nettype wire
